inst_queue: RTL and testbench

//  FIFO between the fetcher and the decode/dispatch stage. It buffers fetched instructions with their PC and predicted-taken bit.
//  An entry is released to the decoder only when RS, LSB and ROB all report a free slot, so every popped instruction can be accepted.
//  The whole queue is discarded on a ROB misbranch.

---
 rtl/inst_queue.sv | 122 ++++++++++++
 tb/tb_inst_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular FIFO of {inst, pc, pred} entries that
// releases one entry per cycle only when RS, LSB and ROB can all accept it.
module inst_queue #(
   parameter int unsigned IQ_SIZE  = 16,
   parameter int unsigned IQ_WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        in_fetcher_flag,
   input  logic [31:0] in_fetcher_inst,
   input  logic [31:0] in_fetcher_pc,
   input  logic        in_fetcher_pred,
   output logic        out_fetcher_full,
   input  logic        in_rs_idle,
   input  logic        in_lsb_idle,
   input  logic        in_rob_idle,
   output logic        out_decoder_flag,
   output logic [31:0] out_decoder_inst,
   output logic [31:0] out_decoder_pc,
   output logic        out_decoder_pred,
   input  logic        in_rob_xbp
);

   localparam logic [IQ_WIDTH:0]   FullCount = (IQ_WIDTH + 1)'(IQ_SIZE);
   localparam logic [IQ_WIDTH:0]   CntOne    = (IQ_WIDTH + 1)'(1);
   localparam logic [IQ_WIDTH-1:0] PtrOne    = IQ_WIDTH'(1);

   logic [31:0] inst_mem [IQ_SIZE];
   logic [31:0] pc_mem   [IQ_SIZE];
   logic        pred_mem [IQ_SIZE];

   logic [IQ_WIDTH-1:0] head_q, head_d;
   logic [IQ_WIDTH-1:0] tail_q, tail_d;
   logic [IQ_WIDTH:0]   count_q, count_d;
   logic                flag_q, flag_d;
   logic [31:0]         inst_q, inst_d;
   logic [31:0]         pc_q, pc_d;
   logic                pred_q, pred_d;

   logic pop;
   logic push;
   logic wr_en;

   // Full is taken from the registered count, so a pop in the same cycle cannot make room.
   assign out_fetcher_full = (count_q == FullCount);

   assign pop  = (count_q != '0) && in_rs_idle && in_lsb_idle && in_rob_idle;
   assign push = in_fetcher_flag && !out_fetcher_full;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      flag_d  = flag_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      pred_d  = pred_q;
      wr_en   = 1'b0;

      if (rdy) begin
         if (in_rob_xbp) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            flag_d  = 1'b0;
         end else begin
            flag_d = pop;
            if (pop) begin
               inst_d = inst_mem[head_q];
               pc_d   = pc_mem[head_q];
               pred_d = pred_mem[head_q];
               head_d = head_q + PtrOne;
            end
            if (push) begin
               wr_en  = 1'b1;
               tail_d = tail_q + PtrOne;
            end
            case ({push, pop})
               2'b10:   count_d = count_q + CntOne;
               2'b01:   count_d = count_q - CntOne;
               default: count_d = count_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         flag_q  <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
         pred_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         flag_q  <= flag_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         pred_q  <= pred_d;
      end
   end

   // Entry storage needs no reset: occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         inst_mem[tail_q] <= in_fetcher_inst;
         pc_mem[tail_q]   <= in_fetcher_pc;
         pred_mem[tail_q] <= in_fetcher_pred;
      end
   end

   assign out_decoder_flag = flag_q;
   assign out_decoder_inst = inst_q;
   assign out_decoder_pc   = pc_q;
   assign out_decoder_pred = pred_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model compared every cycle, directed
// fill/drain/steady/stall/flush/reset/rdy scenarios, then a randomized phase.
module tb_inst_queue;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        in_fetcher_flag = 1'b0;
   logic [31:0] in_fetcher_inst = '0;
   logic [31:0] in_fetcher_pc = '0;
   logic        in_fetcher_pred = 1'b0;
   logic        out_fetcher_full;
   logic        in_rs_idle = 1'b0;
   logic        in_lsb_idle = 1'b0;
   logic        in_rob_idle = 1'b0;
   logic        out_decoder_flag;
   logic [31:0] out_decoder_inst;
   logic [31:0] out_decoder_pc;
   logic        out_decoder_pred;
   logic        in_rob_xbp = 1'b0;

   int n_checks = 0;
   int n_fails  = 0;
   bit chk_en   = 1'b0;

   inst_queue #(.IQ_SIZE(16), .IQ_WIDTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .in_fetcher_flag  (in_fetcher_flag),
      .in_fetcher_inst  (in_fetcher_inst),
      .in_fetcher_pc    (in_fetcher_pc),
      .in_fetcher_pred  (in_fetcher_pred),
      .out_fetcher_full (out_fetcher_full),
      .in_rs_idle       (in_rs_idle),
      .in_lsb_idle      (in_lsb_idle),
      .in_rob_idle      (in_rob_idle),
      .out_decoder_flag (out_decoder_flag),
      .out_decoder_inst (out_decoder_inst),
      .out_decoder_pc   (out_decoder_pc),
      .out_decoder_pred (out_decoder_pred),
      .in_rob_xbp       (in_rob_xbp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pending entries plus the expected output register.
   ent_t        mq[$];
   logic        m_flag;
   logic [31:0] m_inst;
   logic [31:0] m_pc;
   logic        m_pred;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_flag = 1'b0;
         m_inst = '0;
         m_pc   = '0;
         m_pred = 1'b0;
      end else if (rdy) begin
         if (in_rob_xbp) begin
            mq.delete();
            m_flag = 1'b0;
         end else begin
            bit do_pop;
            bit do_push;
            ent_t e;
            do_pop  = (mq.size() != 0) && in_rs_idle && in_lsb_idle && in_rob_idle;
            do_push = in_fetcher_flag && (mq.size() < 16);
            m_flag  = do_pop;
            if (do_pop) begin
               e = mq.pop_front();
               m_inst = e.inst;
               m_pc   = e.pc;
               m_pred = e.pred;
            end
            if (do_push) mq.push_back({in_fetcher_inst, in_fetcher_pc, in_fetcher_pred});
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("flag", 64'(out_decoder_flag), 64'(m_flag));
         check("full", 64'(out_fetcher_full), 64'(mq.size() == 16));
         check("inst", 64'(out_decoder_inst), 64'(m_inst));
         check("pc",   64'(out_decoder_pc),   64'(m_pc));
         check("pred", 64'(out_decoder_pred), 64'(m_pred));
      end
   end

   // Drive one cycle of inputs (called just after a falling edge), then advance past the next
   // rising edge to just after the following falling edge.
   task automatic step(input bit push, input logic [31:0] pc, input bit rs, input bit lsb,
                       input bit rob, input bit xbp);
      in_fetcher_flag = push;
      in_fetcher_pc   = pc;
      in_fetcher_inst = $urandom;
      in_fetcher_pred = pc[2];
      in_rs_idle      = rs;
      in_lsb_idle     = lsb;
      in_rob_idle     = rob;
      in_rob_xbp      = xbp;
      @(negedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      chk_en = 1'b1;

      // Fill with downstream stalled; 17th push must be dropped.
      for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_full_after_16", 64'(out_fetcher_full), 64'd1);
      step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_full_after_17", 64'(out_fetcher_full), 64'd1);

      // Drain: 16 back-to-back pulses in PC order.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
         check("t2_flag", 64'(out_decoder_flag), 64'd1);
         check("t2_pc", 64'(out_decoder_pc), 64'(i * 4));
      end
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t2_flag_end", 64'(out_decoder_flag), 64'd0);
      check("t2_full_end", 64'(out_fetcher_full), 64'd0);

      // Steady stream: 2-cycle latency, then one pulse per cycle across several wraps.
      step(1'b1, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t3_no_bypass", 64'(out_decoder_flag), 64'd0);
      step(1'b1, 32'h1004, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t3_first_flag", 64'(out_decoder_flag), 64'd1);
      check("t3_first_pc", 64'(out_decoder_pc), 64'h1000);
      for (int i = 2; i < 50; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t3_last_pc", 64'(out_decoder_pc), 64'h10c4);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);

      // LSB stall with three entries queued, then release.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h2000 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t4_stalled", 64'(out_decoder_flag), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
         check("t4_release_pc", 64'(out_decoder_pc), 64'h2000 + 64'(i * 4));
      end
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t4_done", 64'(out_decoder_flag), 64'd0);

      // Flush with a concurrent push; 0x200 must then pop alone.
      for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1);
      check("t5_flag_after_flush", 64'(out_decoder_flag), 64'd0);
      step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t5_no_stale_pop", 64'(out_decoder_flag), 64'd0);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t5_pop_flag", 64'(out_decoder_flag), 64'd1);
      check("t5_pop_pc", 64'(out_decoder_pc), 64'h200);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t5_alone", 64'(out_decoder_flag), 64'd0);

      // Asynchronous reset between edges while a pop is being presented.
      for (int i = 0; i < 5; i++) step(1'b1, 32'h4000 + 32'(i * 4), 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t6_pre_reset_flag", 64'(out_decoder_flag), 64'd1);
      #1 rst = 1'b0;
      #1;
      check("t6_async_flag", 64'(out_decoder_flag), 64'd0);
      check("t6_async_pc", 64'(out_decoder_pc), 64'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t6_empty_after_reset", 64'(out_decoder_flag), 64'd0);

      // rdy low mid-drain freezes everything, including a pending flag pulse.
      for (int i = 0; i < 6; i++) step(1'b1, 32'h5000 + 32'(i * 4), 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h6000, 1'b1, 1'b1, 1'b1, 1'b0);
         check("t6_frozen_flag", 64'(out_decoder_flag), 64'd1);
         check("t6_frozen_pc", 64'(out_decoder_pc), 64'h5004);
      end
      rdy = 1'b1;
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t6_resume_pc", 64'(out_decoder_pc), 64'h5008);
      repeat (5) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rdy = ($urandom_range(0, 9) != 0);
         step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 4) != 0,
              $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 39) == 0);
      end
      rdy = 1'b1;
      repeat (20) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
